au_gray_counter: RTL and testbench
==================================

# au_gray_counter

Registered up/down counter that keeps a binary state and presents a Gray-coded output (binary→Gray encoder, g = b ^ (b >> 1)). It is the producing end for the arithmetic unit library's Gray→binary prefix converters. Its Gray output is the source-side pointer/position word that a downstream clock-domain crossing or decoder consumes. The block adds load, wrap/saturate policy, terminal flags and a sticky overflow flag.

## Interface
- WIDTH, 8, counter word length (>= 2)
- SAT, 0, overflow policy: 0 = wrap modulo 2^WIDTH, 1 = saturate at the limits
- INIT, 0, binary value loaded on reset (0 to 2^WIDTH-1)

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable: one step per cycle while high
- dn  in  1  direction: 0 = up (+1), 1 = down (-1); sampled only when stepping
- load  in  1  load request
- load_val  in  WIDTH  binary value to load
- cnt_bin  out  WIDTH  registered binary count
- cnt_gray  out  WIDTH  registered Gray code of cnt_bin
- at_max  out  1  registered; 1 when cnt_bin = 2^WIDTH-1
- at_min  out  1  registered; 1 when cnt_bin = 0
- ovf  out  1  sticky overflow/underflow flag

## Operation
- Priority per cycle: rst > load > en. Idle when none of them is active.
- rst: cnt_bin = INIT, cnt_gray = INIT ^ (INIT >> 1), at_max/at_min reflect INIT, ovf = 0.
- load: cnt_bin = load_val and ovf cleared. en and dn are ignored in that cycle.
- en, dn = 0: next = cnt_bin + 1. At cnt_bin = max:
  - SAT = 0: next = 0 and ovf is set.
  - SAT = 1: cnt_bin holds at max and ovf is set.
- en, dn = 1: next = cnt_bin - 1. At cnt_bin = 0:
  - SAT = 0: next = max and ovf is set.
  - SAT = 1: cnt_bin holds at 0 and ovf is set.
- ovf stays set until rst or load. A saturated hold with en still high keeps ovf at 1 and has no other effect.
- cnt_gray, at_max and at_min are computed from the next binary value and registered in the same cycle as cnt_bin. They are never decoded combinationally from the outputs.
- Gray property: every wrap-mode step changes exactly one cnt_gray bit. This includes max→0 and 0→max. A load may change any number of bits.
- Arithmetic is WIDTH-bit unsigned. Carry/borrow out is used only for overflow detection.

## Timing
- Latency is 1 cycle: inputs sampled at edge n are visible on all outputs after edge n.
- There is no combinational path from any input to any output.
- A direction change takes effect on the same edge it is sampled; there is no turnaround bubble.
- Reset asserted mid-count overrides an active load or en at that edge. Counting resumes from INIT on the first edge after rst deasserts.
- load and rst held high over several cycles re-apply every cycle.

## Structure
- Sub-module au_bin2gray (parameter WIDTH): purely combinational binary→Gray encoder, reusable by other blocks. It is instantiated once, on the next-state value feeding the registers.
- The shared constants header holds the SAT policy encodings (SAT_WRAP = 0, SAT_HOLD = 1). It holds nothing else.
- A single always block holds all state registers: cnt_bin, cnt_gray, at_max, at_min, ovf. Expected implementation is about 150 RTL lines.

## Test plan
- Reset, WIDTH=4, INIT=5: assert rst -> cnt_bin=5, cnt_gray=0111, at_max=0, at_min=0, ovf=0, including when load or en are active during rst.
- Up-count from 0, SAT=0, 17 enables:
  - cnt_gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000,0000,0001.
  - at_max is high only at bin 15; ovf is set after the 15→0 wrap.
  - Every step is checked for Hamming distance 1.
- Down-count from 0, SAT=0: one step -> cnt_bin=15, cnt_gray=1000, ovf=1, at_max=1. A second step -> 14 (gray 1001).
- SAT=1: load 14, 3 up-steps -> 15, 15, 15; ovf=1 from the second step. Then 1 down-step -> 14 and ovf stays 1.
- Load priority: en=1, dn=0, load=1, load_val=10 at cnt_bin=3 -> cnt_bin=10, cnt_gray=1111, ovf cleared. The next en step gives 11 (gray 1110).
- Random regression, 10k cycles, random en/dn/load/rst: outputs match the reference model every cycle. cnt_gray always equals cnt_bin ^ (cnt_bin >> 1).

Source files
------------

// File: rtl/au_gray_counter_pkg.sv
// Shared constants for au_gray_counter: overflow policy encodings for the SAT parameter.
package au_gray_counter_pkg;

  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_HOLD = 1;

endpackage

// File: rtl/au_bin2gray.sv
// Combinational binary-to-Gray encoder, g = b ^ (b >> 1).
module au_bin2gray #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/au_gray_counter.sv
// Up/down counter with binary state and registered Gray output, load, wrap/saturate
// policy, terminal flags and a sticky overflow flag.
module au_gray_counter
  import au_gray_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SAT   = SAT_WRAP,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL   = '1;
  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH-1:0] nxt_bin;
  logic [WIDTH-1:0] nxt_gray_c;
  logic             nxt_ovf;

  // One extra bit captures carry/borrow out; the low WIDTH bits are the wrapped result.
  assign up_sum  = {1'b0, cnt_bin} + (WIDTH+1)'(1);
  assign dn_diff = {1'b0, cnt_bin} - (WIDTH+1)'(1);

  // Next-state selection: load beats en; saturation holds the current value.
  always_comb begin
    nxt_bin = cnt_bin;
    nxt_ovf = ovf;
    if (load) begin
      nxt_bin = load_val;
      nxt_ovf = 1'b0;
    end else if (en) begin
      if (!dn) begin
        nxt_bin = (up_sum[WIDTH] && (SAT == SAT_HOLD)) ? cnt_bin : up_sum[WIDTH-1:0];
        nxt_ovf = ovf | up_sum[WIDTH];
      end else begin
        nxt_bin = (dn_diff[WIDTH] && (SAT == SAT_HOLD)) ? cnt_bin : dn_diff[WIDTH-1:0];
        nxt_ovf = ovf | dn_diff[WIDTH];
      end
    end
  end

  au_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin    (nxt_bin),
    .gray_c (nxt_gray_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_bin  <= INIT_BIN;
      cnt_gray <= INIT_GRAY;
      at_max   <= (INIT_BIN == MAX_VAL);
      at_min   <= (INIT_BIN == '0);
      ovf      <= 1'b0;
    end else begin
      cnt_bin  <= nxt_bin;
      cnt_gray <= nxt_gray_c;
      at_max   <= (nxt_bin == MAX_VAL);
      at_min   <= (nxt_bin == '0);
      ovf      <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_au_gray_counter.sv
// Bench for au_gray_counter: a wrapping and a saturating 4-bit instance driven in parallel
// and compared against an integer reference model, plus directed corner cases.
module tb_au_gray_counter;

  localparam int unsigned W    = 4;
  localparam int          MAXV = 15;
  localparam int          INITV = 5;

  logic         clk = 1'b0;
  logic         rst, en, dn, load;
  logic [W-1:0] load_val;

  logic [W-1:0] w_bin, w_gray, s_bin, s_gray;
  logic         w_max, w_min, w_ovf, s_max, s_min, s_ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference state: index 0 = wrap instance, 1 = saturating instance.
  int m_bin [2];
  int m_ovf [2];

  // Gray code of 0..15 written out by hand.
  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  au_gray_counter #(.WIDTH(W), .SAT(0), .INIT(INITV)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dn(dn), .load(load), .load_val(load_val),
    .cnt_bin(w_bin), .cnt_gray(w_gray), .at_max(w_max), .at_min(w_min), .ovf(w_ovf)
  );

  au_gray_counter #(.WIDTH(W), .SAT(1), .INIT(INITV)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dn(dn), .load(load), .load_val(load_val),
    .cnt_bin(s_bin), .cnt_gray(s_gray), .at_max(s_max), .at_min(s_min), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_gray(input int b);
    return gray_tab[b];
  endfunction

  task automatic model_step(input int i, input bit r, input bit l, input int lv,
                            input bit e, input bit d);
    int nb;
    if (r) begin
      m_bin[i] = INITV;
      m_ovf[i] = 0;
    end else if (l) begin
      m_bin[i] = lv;
      m_ovf[i] = 0;
    end else if (e) begin
      nb = d ? m_bin[i] - 1 : m_bin[i] + 1;
      if (nb > MAXV || nb < 0) begin
        m_ovf[i] = 1;
        if (i == 1) nb = m_bin[i];
        else        nb = (nb + MAXV + 1) % (MAXV + 1);
      end
      m_bin[i] = nb;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " wrap bin"},  32'(w_bin),  32'(m_bin[0]));
    chk({tag, " wrap gray"}, 32'(w_gray), 32'(model_gray(m_bin[0])));
    chk({tag, " wrap max"},  32'(w_max),  32'(m_bin[0] == MAXV));
    chk({tag, " wrap min"},  32'(w_min),  32'(m_bin[0] == 0));
    chk({tag, " wrap ovf"},  32'(w_ovf),  32'(m_ovf[0]));
    chk({tag, " sat bin"},   32'(s_bin),  32'(m_bin[1]));
    chk({tag, " sat gray"},  32'(s_gray), 32'(model_gray(m_bin[1])));
    chk({tag, " sat max"},   32'(s_max),  32'(m_bin[1] == MAXV));
    chk({tag, " sat min"},   32'(s_min),  32'(m_bin[1] == 0));
    chk({tag, " sat ovf"},   32'(s_ovf),  32'(m_ovf[1]));
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input bit r, input bit l, input int lv,
                     input bit e, input bit d);
    rst = r; load = l; load_val = W'(lv); en = e; dn = d;
    @(posedge clk);
    #1;
    model_step(0, r, l, lv, e, d);
    model_step(1, r, l, lv, e, d);
    check_model(tag);
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    bit r, l, e, d;
    int lv;
    rst = 1'b1; en = 1'b0; dn = 1'b0; load = 1'b0; load_val = '0;
    m_bin = '{INITV, INITV};
    m_ovf = '{0, 0};
    @(negedge clk);

    // Reset wins over simultaneous load and en.
    cyc("rst", 1, 1, 3, 1, 0);
    chk("rst bin", 32'(w_bin), 32'd5);
    chk("rst gray", 32'(w_gray), 32'b0111);
    chk("rst max/min/ovf", 32'({w_max, w_min, w_ovf}), 32'd0);
    cyc("rst hold", 1, 0, 0, 1, 1);
    chk("rst held bin", 32'(s_bin), 32'd5);

    // Up-count from 0 through the wrap, one Gray bit per step.
    cyc("load0", 0, 1, 0, 0, 0);
    prev_gray = w_gray;
    for (int k = 1; k <= 17; k++) begin
      cyc("up", 0, 0, 0, 1, 0);
      chk("up gray seq", 32'(w_gray), 32'(gray_tab[k % 16]));
      chk("up hamming", 32'($countones(prev_gray ^ w_gray)), 32'd1);
      prev_gray = w_gray;
    end
    chk("up ovf after wrap", 32'(w_ovf), 32'd1);

    // Down-count from 0 wraps to max.
    cyc("load0b", 0, 1, 0, 0, 0);
    cyc("dn1", 0, 0, 0, 1, 1);
    chk("dn wrap bin", 32'(w_bin), 32'd15);
    chk("dn wrap gray", 32'(w_gray), 32'b1000);
    chk("dn wrap ovf/max", 32'({w_ovf, w_max}), 32'b11);
    cyc("dn2", 0, 0, 0, 1, 1);
    chk("dn2 bin", 32'(w_bin), 32'd14);
    chk("dn2 gray", 32'(w_gray), 32'b1001);

    // Saturation at max, then step back down with ovf sticky.
    cyc("load14", 0, 1, 14, 0, 0);
    cyc("sat up1", 0, 0, 0, 1, 0);
    chk("sat up1", 32'({s_bin, s_ovf}), 32'({4'd15, 1'b0}));
    cyc("sat up2", 0, 0, 0, 1, 0);
    chk("sat up2", 32'({s_bin, s_ovf}), 32'({4'd15, 1'b1}));
    cyc("sat up3", 0, 0, 0, 1, 0);
    chk("sat up3", 32'({s_bin, s_ovf}), 32'({4'd15, 1'b1}));
    cyc("sat dn", 0, 0, 0, 1, 1);
    chk("sat dn", 32'({s_bin, s_ovf}), 32'({4'd14, 1'b1}));

    // Load beats en and clears ovf.
    cyc("load3", 0, 1, 3, 0, 0);
    cyc("load prio", 0, 1, 10, 1, 0);
    chk("load prio bin", 32'(w_bin), 32'd10);
    chk("load prio gray", 32'(w_gray), 32'b1111);
    chk("load prio ovf", 32'(w_ovf), 32'd0);
    cyc("after load", 0, 0, 0, 1, 0);
    chk("after load", 32'({w_bin, w_gray}), 32'({4'd11, 4'b1110}));

    // Random regression against the model.
    for (int n = 0; n < 10000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 8);
      e  = ($urandom_range(0, 99) < 75);
      d  = 1'($urandom);
      lv = int'($urandom_range(0, MAXV));
      cyc("rand", r, l, lv, e, d);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
